// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL lock supervisor: synchronizes raw lock, releases system reset after a settle window, counts lock losses.
// Optional build macro: LOCK_GLITCH_FILTER_EN (ignore lk_s low runs shorter than GLITCH_CYCLES while in RUN).
module pll_lock_supervisor #(
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned CNT_WIDTH     = 8,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned GLITCH_CYCLES = 4
) (
  input  logic                 clock_in,
  input  logic                 reset_n,
  input  logic                 locked,
  input  logic                 clear_stats,
  output logic                 sys_reset_n,
  output logic                 ready,
  output logic                 lost_sticky,
  output logic [CNT_WIDTH-1:0] loss_count
);

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_SETTLE    = 2'd1,
    S_RUN       = 2'd2,
    S_LOST      = 2'd3
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [SW-1:0]          r_settle_cnt;
  logic                   w_lk_s;
  logic                   w_loss;
  logic                   w_loss_evt;

  // Synchronized lock: every decision below uses only this signal.
  assign w_lk_s = r_sync[SYNC_STAGES-1];

  // Shift the asynchronous lock input through the synchronizer chain.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], locked};
    end
  end

`ifdef LOCK_GLITCH_FILTER_EN
  localparam int unsigned GW = (GLITCH_CYCLES > 1) ? $clog2(GLITCH_CYCLES) : 1;
  localparam logic [GW-1:0] GLITCH_LAST = GW'(GLITCH_CYCLES - 1);

  logic [GW-1:0] r_low_cnt;

  // A loss is the GLITCH_CYCLES-th consecutive low sample seen in RUN.
  assign w_loss = !w_lk_s && (r_low_cnt == GLITCH_LAST);

  // Count consecutive low samples in RUN; any high sample restarts the run.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_low_cnt <= '0;
    end else if ((r_state != S_RUN) || w_lk_s) begin
      r_low_cnt <= '0;
    end else if (!w_loss) begin
      r_low_cnt <= r_low_cnt + GW'(1);
    end
  end
`else
  logic w_unused_glitch;

  // Without the filter a single low sample in RUN is a loss.
  assign w_loss = !w_lk_s;
  assign w_unused_glitch = ^GLITCH_CYCLES;
`endif

  // A loss only counts when it takes the FSM out of RUN.
  assign w_loss_evt = (r_state == S_RUN) && w_loss;

  // Lock FSM with registered reset/ready outputs so sys_reset_n can never glitch.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_WAIT_LOCK;
      r_settle_cnt <= '0;
      sys_reset_n  <= 1'b0;
      ready        <= 1'b0;
    end else begin
      case (r_state)
        S_WAIT_LOCK: begin
          r_settle_cnt <= '0;
          if (w_lk_s) begin
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (!w_lk_s) begin
            r_state      <= S_WAIT_LOCK;
            r_settle_cnt <= '0;
          end else if (r_settle_cnt == SETTLE_LAST) begin
            r_state      <= S_RUN;
            r_settle_cnt <= '0;
            sys_reset_n  <= 1'b1;
            ready        <= 1'b1;
          end else begin
            r_settle_cnt <= r_settle_cnt + SW'(1);
          end
        end
        S_RUN: begin
          if (w_loss) begin
            r_state     <= S_LOST;
            sys_reset_n <= 1'b0;
            ready       <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_WAIT_LOCK;
          r_settle_cnt <= '0;
          sys_reset_n  <= 1'b0;
          ready        <= 1'b0;
        end
      endcase
    end
  end

  // Debug statistics: a loss in the same cycle as a clear wins over the clear.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      lost_sticky <= 1'b0;
      loss_count  <= '0;
    end else if (w_loss_evt) begin
      lost_sticky <= 1'b1;
      if (clear_stats) begin
        loss_count <= CNT_WIDTH'(1);
      end else if (loss_count != {CNT_WIDTH{1'b1}}) begin
        loss_count <= loss_count + CNT_WIDTH'(1);
      end
    end else if (clear_stats) begin
      lost_sticky <= 1'b0;
      loss_count  <= '0;
    end
  end

endmodule
